// File: rtl/uart_frame_loader.sv
// uart_frame_loader: loads a sync-headed UART image upload into BRAM port A with idle-line abort
module uart_frame_loader #(
  parameter int          IMG_W   = 640,
  parameter int          IMG_H   = 480,
  parameter int          ADDR_W  = 19,
  parameter logic [7:0]  SYNC0   = 8'hAA,
  parameter logic [7:0]  SYNC1   = 8'h55,
  parameter int          TIMEOUT = 5_000_000
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_data,
  output logic              bram_wren,
  output logic              busy,
  output logic              frame_valid,
  output logic              frame_done,
  output logic              err_timeout
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_LOAD} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d, addr_q, addr_d;
  logic [IW-1:0]     idle_cnt_q, idle_cnt_d;
  logic [7:0]        data_q, data_d;
  logic              wren_q, wren_d, busy_q, busy_d, fv_q, fv_d, done_q, done_d, err_q, err_d;
  logic              expire;
  assign expire      = idle_cnt_q == IDLE_MAX;
  assign bram_addr   = addr_q;
  assign bram_data   = data_q;
  assign bram_wren   = wren_q;
  assign busy        = busy_q;
  assign frame_valid = fv_q;
  assign frame_done  = done_q;
  assign err_timeout = err_q;
  // next-state: header hunt, pixel writes and idle-line abort
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    idle_cnt_d = idle_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wren_d     = 1'b0;
    done_d     = 1'b0;
    fv_d       = fv_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: if (rx_valid && rx_data == SYNC0) begin
        state_d    = S_SYNC;
        idle_cnt_d = '0;
      end
      S_SYNC: if (rx_valid) begin
        idle_cnt_d = '0;
        if (rx_data == SYNC1) begin
          state_d   = S_LOAD;
          pix_cnt_d = '0;
          fv_d      = 1'b0;
          err_d     = 1'b0;
        end else if (rx_data != SYNC0) begin
          state_d = S_IDLE;
        end
      end else if (expire) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
      S_LOAD: if (rx_valid) begin
        idle_cnt_d = '0;
        wren_d     = 1'b1;
        addr_d     = pix_cnt_q;
        data_d     = rx_data;
        if (pix_cnt_q == LAST_PIX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          fv_d    = 1'b1;
        end else begin
          pix_cnt_d = pix_cnt_q + ADDR_W'(1);
        end
      end else if (expire) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  // state and registered outputs; reset drops any pending write
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pix_cnt_q  <= '0;
      idle_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
      fv_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
      fv_q       <= fv_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: directed checks of header sync, pixel writes, timeout and reset behaviour
module tb_uart_frame_loader;
  logic       clk_50 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [2:0] bram_addr;
  logic [7:0] bram_data;
  logic       bram_wren, busy, frame_valid, frame_done, err_timeout;
  int         passed = 0;
  int         total = 0;
  int         cyc = 0;
  logic [2:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];
  int         done_cnt = 0;
  logic [2:0] done_addr = '0;
  logic       done_wr = 1'b0;

  uart_frame_loader #(.IMG_W(4), .IMG_H(2), .ADDR_W(3), .SYNC0(8'hAA), .SYNC1(8'h55), .TIMEOUT(20)) dut (
    .clk_50(clk_50), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .bram_addr(bram_addr), .bram_data(bram_data), .bram_wren(bram_wren), .busy(busy),
    .frame_valid(frame_valid), .frame_done(frame_done), .err_timeout(err_timeout)
  );

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc++;
  always @(negedge clk_50) begin
    if (bram_wren) begin
      wa.push_back(bram_addr);
      wd.push_back(bram_data);
      wc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      done_addr = bram_addr;
      done_wr = bram_wren;
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk_50);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gap(3);
    total++;
    if ({bram_addr, bram_data, bram_wren, busy, frame_valid, frame_done, err_timeout} !== '0)
      $display("FAIL reset_outputs got %h want 0", {bram_addr, bram_data, bram_wren, busy, frame_valid, frame_done, err_timeout});
    else passed++;
    rst = 1'b0;
    gap(1);
  endtask

  task automatic test_normal();
    clear_log();
    send(8'hAA);
    total++;
    if (busy !== 1'b1) $display("FAIL normal_busy_sync got %b want 1", busy); else passed++;
    gap(2);
    send(8'h55);
    gap(2);
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i));
      gap(2);
    end
    total++;
    if (wa.size() != 8) $display("FAIL normal_count got %0d want 8", wa.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (wa[i] !== 3'(i) || wd[i] !== 8'h10 + 8'(i))
        $display("FAIL normal_write%0d got %0h/%0h want %0h/%0h", i, wa[i], wd[i], i, 8'h10 + 8'(i));
      else passed++;
    end
    total++;
    if (done_cnt != 1 || done_addr !== 3'd7 || done_wr !== 1'b1)
      $display("FAIL normal_done got cnt=%0d addr=%0d wren=%b want 1/7/1", done_cnt, done_addr, done_wr);
    else passed++;
    total++;
    if (frame_valid !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0)
      $display("FAIL normal_status got fv=%b busy=%b err=%b want 1/0/0", frame_valid, busy, err_timeout);
    else passed++;
  endtask

  task automatic test_resync();
    clear_log();
    send(8'h00); gap(1);
    send(8'hAA); gap(1);
    send(8'hAA); gap(1);
    send(8'h12);
    total++;
    if (busy !== 1'b0 || wa.size() != 0)
      $display("FAIL resync_drop got busy=%b writes=%0d want 0/0", busy, wa.size());
    else passed++;
    gap(1);
    send(8'hAA); gap(1);
    send(8'h55);
    total++;
    if (busy !== 1'b1 || frame_valid !== 1'b0 || wa.size() != 0)
      $display("FAIL resync_header got busy=%b fv=%b writes=%0d want 1/0/0", busy, frame_valid, wa.size());
    else passed++;
    gap(1);
    for (int i = 0; i < 8; i++) begin
      send(8'h20 + 8'(i));
      gap(1);
    end
    gap(1);
    total++;
    if (wa.size() != 8) $display("FAIL resync_count got %0d want 8", wa.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (wa[i] !== 3'(i) || wd[i] !== 8'h20 + 8'(i))
        $display("FAIL resync_write%0d got %0h/%0h want %0h/%0h", i, wa[i], wd[i], i, 8'h20 + 8'(i));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send(8'hAA);
    send(8'h55);
    for (int i = 0; i < 8; i++) send(i % 2 == 1 ? 8'h55 : 8'hAA);
    gap(2);
    total++;
    if (wa.size() != 8) $display("FAIL b2b_count got %0d want 8", wa.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (wa[i] !== 3'(i) || wd[i] !== (i % 2 == 1 ? 8'h55 : 8'hAA) || wc[i] != wc[0] + i)
        $display("FAIL b2b_write%0d got %0h/%0h cyc+%0d want %0h/%0h cyc+%0d", i, wa[i], wd[i], wc[i] - wc[0], i, (i % 2 == 1 ? 8'h55 : 8'hAA), i);
      else passed++;
    end
    total++;
    if (done_cnt != 1 || frame_valid !== 1'b1)
      $display("FAIL b2b_done got cnt=%0d fv=%b want 1/1", done_cnt, frame_valid);
    else passed++;
  endtask

  task automatic test_timeout();
    clear_log();
    send(8'hAA);
    send(8'h55);
    total++;
    if (frame_valid !== 1'b0) $display("FAIL timeout_fv_clear got %b want 0", frame_valid); else passed++;
    send(8'h30);
    send(8'h31);
    send(8'h32);
    gap(19);
    total++;
    if (busy !== 1'b1 || err_timeout !== 1'b0)
      $display("FAIL timeout_early got busy=%b err=%b want 1/0", busy, err_timeout);
    else passed++;
    gap(1);
    total++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || frame_valid !== 1'b0 || wa.size() != 3)
      $display("FAIL timeout_abort got err=%b busy=%b fv=%b writes=%0d want 1/0/0/3", err_timeout, busy, frame_valid, wa.size());
    else passed++;
    clear_log();
    send(8'hAA);
    total++;
    if (err_timeout !== 1'b1) $display("FAIL timeout_sticky got %b want 1", err_timeout); else passed++;
    send(8'h55);
    total++;
    if (err_timeout !== 1'b0) $display("FAIL timeout_clear got %b want 0", err_timeout); else passed++;
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i));
    gap(2);
    total++;
    if (wa.size() != 8 || wa[0] !== 3'd0 || wd[0] !== 8'h40 || wa[7] !== 3'd7 || frame_valid !== 1'b1)
      $display("FAIL timeout_reload got n=%0d a0=%0d d0=%0h a7=%0d fv=%b want 8/0/40/7/1", wa.size(), wa[0], wd[0], wa[7], frame_valid);
    else passed++;
  endtask

  task automatic test_race();
    clear_log();
    send(8'hAA);
    send(8'h55);
    send(8'h50);
    gap(19);
    send(8'h51);
    total++;
    if (busy !== 1'b1 || err_timeout !== 1'b0)
      $display("FAIL race_no_abort got busy=%b err=%b want 1/0", busy, err_timeout);
    else passed++;
    gap(1);
    total++;
    if (wa.size() != 2 || wa[1] !== 3'd1 || wd[1] !== 8'h51)
      $display("FAIL race_write got n=%0d a=%0d d=%0h want 2/1/51", wa.size(), wa[1], wd[1]);
    else passed++;
    for (int i = 0; i < 6; i++) send(8'h52 + 8'(i));
    gap(2);
    total++;
    if (wa.size() != 8 || frame_valid !== 1'b1 || done_cnt != 1)
      $display("FAIL race_finish got n=%0d fv=%b done=%0d want 8/1/1", wa.size(), frame_valid, done_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    clear_log();
    send(8'hAA);
    send(8'h55);
    for (int i = 0; i < 4; i++) send(8'h60 + 8'(i));
    rst = 1'b1;
    rx_data = 8'h64;
    rx_valid = 1'b1;
    @(negedge clk_50);
    rst = 1'b0;
    rx_valid = 1'b0;
    total++;
    if ({bram_addr, bram_data, bram_wren, busy, frame_valid, frame_done, err_timeout} !== '0)
      $display("FAIL rstmid_outputs got %h want 0", {bram_addr, bram_data, bram_wren, busy, frame_valid, frame_done, err_timeout});
    else passed++;
    gap(3);
    total++;
    if (wa.size() != 4 || wd[3] !== 8'h63)
      $display("FAIL rstmid_writes got n=%0d last=%0h want 4/63", wa.size(), wd[3]);
    else passed++;
    clear_log();
    send(8'hAA);
    send(8'h55);
    for (int i = 0; i < 8; i++) send(8'h70 + 8'(i));
    gap(2);
    total++;
    if (wa.size() != 8 || wa[0] !== 3'd0 || wd[0] !== 8'h70 || frame_valid !== 1'b1 || done_cnt != 1)
      $display("FAIL rstmid_reload got n=%0d a0=%0d d0=%0h fv=%b done=%0d want 8/0/70/1/1", wa.size(), wa[0], wd[0], frame_valid, done_cnt);
    else passed++;
  endtask

  initial begin
    @(negedge clk_50);
    test_reset();
    test_normal();
    test_resync();
    test_back_to_back();
    test_timeout();
    test_race();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Sequences an uploaded image from the UART receiver into the image BRAM (port A) on the `clk_50` domain. It waits for a two-byte sync header, then writes exactly `IMG_W*IMG_H` pixel bytes to consecutive addresses starting at 0. It reports frame completion to the display side and aborts cleanly on line silence, replacing the free-running address counter in front of the BRAM.

## Interface
Parameters:
- `IMG_W`, 640, pixels per line
- `IMG_H`, 480, lines per frame
- `ADDR_W`, 19, BRAM address width; must satisfy `2^ADDR_W >= IMG_W*IMG_H`
- `SYNC0`, 8'hAA, first header byte
- `SYNC1`, 8'h55, second header byte
- `TIMEOUT`, 5_000_000, idle `clk_50` cycles (100 ms) tolerated between bytes once a header has started

Ports:
- `clk_50`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `rx_data`  in  8  byte from UART receiver
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid
- `bram_addr`  out  ADDR_W  port A address
- `bram_data`  out  8  port A write data
- `bram_wren`  out  1  port A write enable
- `busy`  out  1  high in SYNC or LOAD
- `frame_valid`  out  1  BRAM holds a complete frame
- `frame_done`  out  1  one-cycle pulse on last pixel write
- `err_timeout`  out  1  sticky abort flag

## Operation
- Single clock, synchronous active-high reset. All outputs are registered.
- `N = IMG_W*IMG_H`. `pix_cnt` is ADDR_W bits wide. `idle_cnt` is wide enough to hold `TIMEOUT`.
- IDLE:
  - `rx_valid && rx_data==SYNC0` -> SYNC.
  - Any other byte is discarded.
- SYNC:
  - `rx_valid && rx_data==SYNC1` -> LOAD. Clear `pix_cnt` and `frame_valid`.
  - `rx_valid && rx_data==SYNC0` -> stay in SYNC.
  - Any other byte -> IDLE.
- LOAD:
  - Every `rx_valid` produces one write of `rx_data` to address `pix_cnt`, then `pix_cnt` increments.
  - Header-valued bytes inside LOAD are pixel data.
  - On the write with `pix_cnt==N-1`: pulse `frame_done`, set `frame_valid`, go to IDLE. The address never exceeds N-1.
- Timeout, in SYNC and LOAD only:
  - `idle_cnt` clears on every `rx_valid` and on entering SYNC.
  - It increments on every other cycle.
  - At `idle_cnt==TIMEOUT-1` with no `rx_valid`: go to IDLE and set `err_timeout`. `frame_valid` stays 0 when the abort happens in LOAD.
  - A byte arriving in the same cycle as expiry wins; no timeout fires.
- `err_timeout` clears only on `rst` or on entering LOAD.
- `busy` is 1 exactly when the state is SYNC or LOAD.
- Reset mid-LOAD: return to IDLE immediately, drop any pending write, and leave BRAM contents untouched.

## Timing
- Reset values:
  - state IDLE
  - `bram_addr` 0, `bram_data` 0, `bram_wren` 0
  - `busy` 0, `frame_valid` 0, `frame_done` 0, `err_timeout` 0
- Write latency: `rx_valid` in cycle t gives `bram_wren=1` in cycle t+1, with `bram_addr` and `bram_data` stable in the same cycle. `bram_wren` is high for exactly one cycle per accepted pixel.
- `frame_done` and `frame_valid` rise in the same cycle as the last `bram_wren`.
- Back-to-back `rx_valid` (every cycle) is supported with no drops.
- State and `busy` update in cycle t+1 relative to the byte that causes the transition.
- After a frame completes, the next `SYNC0` starts a new upload; the last frame stays valid until SYNC1 is accepted.

## Test plan
Use `IMG_W=4, IMG_H=2, TIMEOUT=20` unless stated.
- Normal frame:
  - Stimulus: AA 55 then 8 bytes 10..17, one strobe every 3 cycles.
  - Required: writes at addresses 0..7 with data 10..17; one `frame_done` pulse aligned with the address-7 write; `frame_valid=1`; `busy=0` afterwards.
- Header resync:
  - Stimulus: 00 AA AA 12 AA 55 then 8 bytes.
  - Required: no writes before the final 55; 8 writes at addresses 0..7; 12 causes a return to IDLE.
- Back-to-back and in-band header:
  - Stimulus: AA 55 then AA 55 AA 55 AA 55 AA 55 with `rx_valid` held high.
  - Required: 8 consecutive `bram_wren` cycles at addresses 0..7 with data alternating AA/55; `frame_done` once.
- Timeout:
  - Stimulus: AA 55, 3 pixels, then 20 silent cycles.
  - Required: `err_timeout=1`, state IDLE, `frame_valid=0`.
  - Then a full new frame: `err_timeout` clears on the 55, writes restart at address 0.
- Expiry race:
  - Stimulus: a byte arrives exactly at cycle 19 of silence.
  - Required: no abort; the byte is written.
- Reset mid-LOAD:
  - Stimulus: assert `rst` after 4 pixels.
  - Required: next cycle all outputs at reset values, no further writes; a subsequent frame writes from address 0.
